// File: rtl/ex34_sweep_ctrl.sv
// ex34_sweep_ctrl
// Sequencer that sweeps every input vector of the 4-input / 7-output
// example_3_4 combinational block. Each vector is held for SETTLE cycles,
// then the response is folded into a 16-bit MISR. When the sweep ends, the
// signature is compared against GOLDEN.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle sweep request, honoured only in IDLE
//   abort      terminate a running sweep, return to IDLE on the next edge
//   vec_o      vector driven to the datapath, {A,B,C,D}
//   vec_valid  vec_o is part of a running sweep
//   resp_i     datapath response {E,F,G}
//   busy       high while settling or sampling
//   done       one-cycle pulse on normal completion
//   pass       signature == GOLDEN, valid from done until start/abort/reset
//   signature  current MISR value
module ex34_sweep_ctrl #(
  parameter int unsigned VEC_W    = 4,
  parameter int unsigned RESP_W   = 7,
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] SIG_SEED = 16'hFFFF,
  parameter logic [15:0] SIG_POLY = 16'h1021,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [VEC_W-1:0]  vec_o,
  output logic              vec_valid,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  localparam int unsigned    NUM_VEC  = 2 ** VEC_W;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);
  localparam logic [VEC_W-1:0] VEC_ZERO = VEC_W'(0);
  localparam logic [7:0]     CNT_LOAD = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // One MISR shift: left shift with polynomial feedback, response XORed in
  // zero-extended to the signature width.
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [RESP_W-1:0] resp);
    logic [15:0] fb;
    fb = sig[15] ? SIG_POLY : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ 16'(resp);
  endfunction

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      sig_next_s;

  assign sig_next_s = misr_step(sig_q, resp_i);

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        // abort beats a simultaneous start; nothing changes in that case
        if (start && !abort) begin
          state_d = ST_SETTLE;
          vec_d   = VEC_ZERO;
          sig_d   = SIG_SEED;
          pass_d  = 1'b0;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = VEC_ZERO;
          pass_d  = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        // an aborted sample leaves the signature untouched
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = VEC_ZERO;
          pass_d  = 1'b0;
        end else if (vec_q == LAST_VEC) begin
          sig_d   = sig_next_s;
          state_d = ST_DONE;
          // registered here so pass is already valid while done is high
          pass_d  = (sig_next_s == GOLDEN);
        end else begin
          sig_d   = sig_next_s;
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = VEC_ZERO;
        if (abort) begin
          pass_d = 1'b0;
        end else begin
          pass_d = pass_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = VEC_ZERO;
        pass_d  = 1'b0;
      end
    endcase
    // status flags are decoded from the next state so they come out of flops
    valid_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    busy_d  = valid_d;
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= VEC_ZERO;
      cnt_q   <= 8'd0;
      sig_q   <= SIG_SEED;
      pass_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vec_o     = vec_q;
  assign vec_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_ex34_sweep_ctrl.sv
// Self-checking bench for ex34_sweep_ctrl. A behavioural example_3_4 model
// and a MISR reference computed with plain integer arithmetic supply every
// expected value; the sweep timeline is predicted from the cycle index.
module tb_ex34_sweep_ctrl;

  localparam logic [15:0] SEED = 16'hFFFF;
  localparam logic [15:0] POLY = 16'h1021;

  // Behavioural stand-in for the example_3_4 datapath: {E,F,G[4:0]}
  function automatic logic [6:0] ex34(input logic [3:0] v);
    logic e, f;
    logic [4:0] g;
    e = (v[3] & v[2]) | v[0];
    f = ^v;
    g = {1'b0, v} + 5'd3;
    return {e, f, g};
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [6:0] r);
    int t;
    t = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) t = t ^ int'(POLY);
    t = t ^ int'(r);
    return 16'(t);
  endfunction

  function automatic logic [15:0] ex34_golden();
    logic [15:0] s;
    s = SEED;
    for (int v = 0; v < 16; v++) s = model_step(s, ex34(4'(v)));
    return s;
  endfunction

  localparam logic [15:0] GOLDEN_REF = ex34_golden();

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [6:0] resp_i;
  logic [3:0] vec_o;
  logic vec_valid, busy, done, pass;
  logic [15:0] signature;

  int checks = 0;
  int failures = 0;
  logic [6:0] tbl [16];
  logic exp_pass = 1'b0;

  always #5 clk = ~clk;

  ex34_sweep_ctrl #(.GOLDEN(GOLDEN_REF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_o(vec_o), .vec_valid(vec_valid), .resp_i(resp_i),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  // mode 0: all zero, 1: example_3_4, 2: example_3_4 with bit flip at vector 9, 3: random
  task automatic fill_table(input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        0: tbl[v] = 7'd0;
        1: tbl[v] = ex34(4'(v));
        2: tbl[v] = (v == 9) ? (ex34(4'(v)) ^ 7'h04) : ex34(4'(v));
        default: tbl[v] = 7'($urandom);
      endcase
    end
  endtask

  function automatic logic [15:0] partial_sig(input int n);
    logic [15:0] s;
    s = SEED;
    for (int v = 0; v < n; v++) s = model_step(s, tbl[v]);
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_i = 7'd0;
    #23;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({vec_o, vec_valid, busy, done, pass} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=00", {vec_o, vec_valid, busy, done, pass});
    end
    checks++;
    if (signature !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_signature got=%h want=ffff", signature);
    end
    exp_pass = 1'b0;
  endtask

  // Runs one sweep; optional mid-sweep start, abort, or async reset at cycle k.
  task automatic run_sweep(input string name, input int mid_start_k,
                           input int abort_k, input int reset_k);
    logic [15:0] exp_sig;
    logic [6:0]  exp_tuple;
    bit          seen_done;
    exp_sig = partial_sig(16);
    @(negedge clk);
    start = 1'b1;
    resp_i = 7'($urandom);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k < 48)       exp_tuple = {4'(k / 3), 1'b1, 1'b1, 1'b0};
      else if (k == 48) exp_tuple = {4'd15, 1'b0, 1'b0, 1'b1};
      else              exp_tuple = {4'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if ({vec_o, vec_valid, busy, done} !== exp_tuple) begin
        failures++;
        $display("FAIL %s timeline k=%0d got=%h want=%h", name, k,
                 {vec_o, vec_valid, busy, done}, exp_tuple);
      end
      if (k == 0) begin
        checks++;
        if (pass !== 1'b0) begin
          failures++;
          $display("FAIL %s pass_clear got=%b want=0", name, pass);
        end
      end
      if (k == 48) begin
        exp_pass = (exp_sig == GOLDEN_REF);
        checks++;
        if (signature !== exp_sig) begin
          failures++;
          $display("FAIL %s signature got=%h want=%h", name, signature, exp_sig);
        end
      end
      if (k >= 48) begin
        checks++;
        if (pass !== exp_pass) begin
          failures++;
          $display("FAIL %s pass k=%0d got=%b want=%b", name, k, pass, exp_pass);
        end
      end
      if (k == abort_k) begin
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if ({vec_o, vec_valid, busy, done, pass} !== 8'h00) begin
          failures++;
          $display("FAIL %s abort_outputs got=%h want=00", name,
                   {vec_o, vec_valid, busy, done, pass});
        end
        checks++;
        if (signature !== partial_sig(k / 3)) begin
          failures++;
          $display("FAIL %s abort_signature got=%h want=%h", name, signature,
                   partial_sig(k / 3));
        end
        exp_pass = 1'b0;
        seen_done = 1'b0;
        repeat (60) begin
          @(negedge clk);
          if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
          failures++;
          $display("FAIL %s activity_after_abort got=1 want=0", name);
        end
        return;
      end
      if (k == reset_k) begin
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_o, vec_valid, busy, done, pass} !== 8'h00 || signature !== 16'hFFFF) begin
          failures++;
          $display("FAIL %s async_reset got=%h/%h want=00/ffff", name,
                   {vec_o, vec_valid, busy, done, pass}, signature);
        end
        exp_pass = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      // real response only ahead of a sampling edge, noise otherwise
      resp_i = (k % 3 == 2 && k < 48) ? tbl[k / 3] : 7'($urandom);
      start  = (k == mid_start_k) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_start_abort_idle();
    logic [15:0] sig_before;
    logic        pass_before;
    sig_before  = signature;
    pass_before = pass;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({vec_o, vec_valid, busy, done, pass} !== {7'h00, pass_before} ||
        signature !== sig_before) begin
      failures++;
      $display("FAIL start_abort_idle got=%h/%h want=%h/%h",
               {vec_o, vec_valid, busy, done, pass}, signature,
               {7'h00, pass_before}, sig_before);
    end
  endtask

  task automatic test_idle_after_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({vec_o, vec_valid, busy, done, pass} !== 8'h00 || signature !== 16'hFFFF) begin
      failures++;
      $display("FAIL idle_after_reset got=%h/%h want=00/ffff",
               {vec_o, vec_valid, busy, done, pass}, signature);
    end
  endtask

  initial begin
    test_reset();
    fill_table(0); run_sweep("zero_resp", -1, -1, -1);
    fill_table(1); run_sweep("ex34", -1, -1, -1);
    fill_table(2); run_sweep("ex34_flip9", -1, -1, -1);
    test_start_abort_idle();
    fill_table(1); run_sweep("abort_vec7", -1, 23, -1);
    fill_table(1); run_sweep("after_abort", -1, -1, -1);
    fill_table(3); run_sweep("mid_start", 9, -1, -1);
    for (int i = 0; i < 3; i++) begin
      fill_table(3); run_sweep("random", -1, -1, -1);
    end
    test_start_abort_idle();
    fill_table(3); run_sweep("reset_vec12", -1, -1, 36);
    test_idle_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
